// File: rtl/vector_dependency_check_if.sv
// Allocator-side bundle for the vector dependency checker: candidate
// instruction fields, issue/done pulses, and per-group conflict/busy status.
interface vector_dependency_check_if #(
  parameter int unsigned W_PORTS_NUM = 4,
  parameter int unsigned VREG_W      = 5
);
  logic                   instr_vld_i;
  logic [VREG_W-1:0]      vs1_i;
  logic [VREG_W-1:0]      vs2_i;
  logic [VREG_W-1:0]      vd_i;
  logic                   vs1_used_i;
  logic                   vs2_used_i;
  logic                   vd_src_i;
  logic                   vd_write_i;
  logic [1:0]             lmul_i;
  logic [W_PORTS_NUM-1:0] start_i;
  logic [W_PORTS_NUM-1:0] port_done_i;
  logic [W_PORTS_NUM-1:0] dependancy_issue_o;
  logic [W_PORTS_NUM-1:0] busy_o;
  logic                   all_idle_o;

  modport master (
    output instr_vld_i, vs1_i, vs2_i, vd_i, vs1_used_i, vs2_used_i, vd_src_i,
    output vd_write_i, lmul_i, start_i, port_done_i,
    input  dependancy_issue_o, busy_o, all_idle_o
  );

  modport slave (
    input  instr_vld_i, vs1_i, vs2_i, vd_i, vs1_used_i, vs2_used_i, vd_src_i,
    input  vd_write_i, lmul_i, start_i, port_done_i,
    output dependancy_issue_o, busy_o, all_idle_o
  );
endinterface

// File: rtl/vector_dependency_check.sv
// Tracks the destination register group of each in-flight write-port group and
// flags RAW/WAW overlaps of the candidate instruction against them.
module vector_dependency_check #(
  parameter int unsigned W_PORTS_NUM = 4,
  parameter int unsigned VREG_W      = 5
) (
  input logic                      clk,
  input logic                      rstn,
  vector_dependency_check_if.slave bus
);

  typedef logic [VREG_W:0] rng_t;

  logic                   valid_q [W_PORTS_NUM];
  logic                   valid_d [W_PORTS_NUM];
  logic [VREG_W-1:0]      base_q  [W_PORTS_NUM];
  logic [VREG_W-1:0]      base_d  [W_PORTS_NUM];
  logic [1:0]             size_q  [W_PORTS_NUM];
  logic [1:0]             size_d  [W_PORTS_NUM];
  logic [W_PORTS_NUM-1:0] raw;
  logic [W_PORTS_NUM-1:0] waw;
  logic [W_PORTS_NUM-1:0] busy;

  // One extra bit keeps v31 with a large group from wrapping back onto v0.
  function automatic rng_t range_hi(input logic [VREG_W-1:0] b, input logic [1:0] s);
    rng_t span;
    span = rng_t'(1) << s;
    return {1'b0, b} + span - rng_t'(1);
  endfunction

  function automatic logic overlap(input logic [VREG_W-1:0] base_a, input logic [1:0] size_a,
                                   input logic [VREG_W-1:0] base_b, input logic [1:0] size_b);
    return ({1'b0, base_a} <= range_hi(base_b, size_b)) &&
           ({1'b0, base_b} <= range_hi(base_a, size_a));
  endfunction

  // A start with a valid candidate overrides a coincident done on the same group.
  always_comb begin
    for (int i = 0; i < W_PORTS_NUM; i++) begin
      valid_d[i] = valid_q[i];
      base_d[i]  = base_q[i];
      size_d[i]  = size_q[i];
      if (bus.start_i[i] && bus.instr_vld_i) begin
        valid_d[i] = bus.vd_write_i;
        if (bus.vd_write_i) begin
          base_d[i] = bus.vd_i;
          size_d[i] = bus.lmul_i;
        end
      end else if (bus.port_done_i[i]) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < W_PORTS_NUM; i++) begin
        valid_q[i] <= 1'b0;
        base_q[i]  <= '0;
        size_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < W_PORTS_NUM; i++) begin
        valid_q[i] <= valid_d[i];
        base_q[i]  <= base_d[i];
        size_q[i]  <= size_d[i];
      end
    end
  end

  always_comb begin
    raw  = '0;
    waw  = '0;
    busy = '0;
    for (int i = 0; i < W_PORTS_NUM; i++) begin
      busy[i] = valid_q[i];
      raw[i]  = valid_q[i] &&
                ((bus.vs1_used_i && overlap(base_q[i], size_q[i], bus.vs1_i, bus.lmul_i)) ||
                 (bus.vs2_used_i && overlap(base_q[i], size_q[i], bus.vs2_i, bus.lmul_i)) ||
                 (bus.vd_src_i   && overlap(base_q[i], size_q[i], bus.vd_i,  bus.lmul_i)));
      waw[i]  = valid_q[i] && bus.vd_write_i &&
                overlap(base_q[i], size_q[i], bus.vd_i, bus.lmul_i);
    end
  end

  assign bus.dependancy_issue_o = bus.instr_vld_i ? (raw | waw) : '0;
  assign bus.busy_o             = busy;
  assign bus.all_idle_o         = (busy == '0);

endmodule

// File: tb/tb_vector_dependency_check.sv
// Directed-vector bench: the driver queues expected outputs, a negedge monitor
// pops and compares them against the DUT.
module tb_vector_dependency_check;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic chk_vld = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct {
    string      name;
    logic [3:0] dep;
    logic [3:0] busy;
    logic       idle;
  } exp_t;

  exp_t sb[$];

  vector_dependency_check_if #(.W_PORTS_NUM(4), .VREG_W(5)) bus ();

  vector_dependency_check #(.W_PORTS_NUM(4), .VREG_W(5)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_vld) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_empty: check strobe with no expected entry");
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_tests++;
        if (bus.dependancy_issue_o !== e.dep || bus.busy_o !== e.busy ||
            bus.all_idle_o !== e.idle) begin
          n_fail++;
          $display("FAIL %s: got dep=%b busy=%b idle=%b, want dep=%b busy=%b idle=%b",
                   e.name, bus.dependancy_issue_o, bus.busy_o, bus.all_idle_o,
                   e.dep, e.busy, e.idle);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    chk_vld = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [3:0] dep, input logic [3:0] busy);
    exp_t e;
    e.name = nm;
    e.dep  = dep;
    e.busy = busy;
    e.idle = (busy == 4'b0000);
    sb.push_back(e);
    chk_vld = 1'b1;
  endtask

  task automatic cand(input logic vld, input logic [4:0] vs1, input logic u1,
                      input logic [4:0] vs2, input logic u2, input logic [4:0] vd,
                      input logic vsrc, input logic vw, input logic [1:0] lmul);
    bus.instr_vld_i = vld;
    bus.vs1_i       = vs1;
    bus.vs1_used_i  = u1;
    bus.vs2_i       = vs2;
    bus.vs2_used_i  = u2;
    bus.vd_i        = vd;
    bus.vd_src_i    = vsrc;
    bus.vd_write_i  = vw;
    bus.lmul_i      = lmul;
  endtask

  task automatic ctl(input logic [3:0] start, input logic [3:0] done);
    bus.start_i     = start;
    bus.port_done_i = done;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cand(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ctl(4'b0000, 4'b0000);
    rstn = 1'b0;
    tick();
    tick();
    expect_out("reset_state", 4'b0000, 4'b0000);
    tick();
    rstn = 1'b1;

    // Group 0 <- v4, no self-conflict in the issue cycle
    cand(1, 0, 0, 0, 0, 4, 0, 1, 0);
    ctl(4'b0001, 4'b0000);
    expect_out("issue_no_self", 4'b0000, 4'b0000);
    tick();
    cand(1, 0, 0, 4, 1, 0, 0, 0, 0);
    ctl(4'b0000, 4'b0000);
    expect_out("raw_vs2_v4", 4'b0001, 4'b0001);
    tick();
    cand(0, 0, 0, 4, 1, 0, 0, 0, 0);
    ctl(4'b0010, 4'b0000);
    expect_out("vld_low_masks", 4'b0000, 4'b0001);
    tick();
    ctl(4'b0000, 4'b0000);
    expect_out("start_ignored", 4'b0000, 4'b0001);
    tick();

    // Group 1 <- v8..v11
    cand(1, 0, 0, 0, 0, 8, 0, 1, 2);
    ctl(4'b0010, 4'b0000);
    expect_out("issue_g1", 4'b0000, 4'b0001);
    tick();
    ctl(4'b0000, 4'b0000);
    cand(1, 0, 0, 0, 0, 10, 0, 1, 0);
    expect_out("waw_v10", 4'b0010, 4'b0011);
    tick();
    cand(1, 0, 0, 0, 0, 12, 0, 1, 0);
    expect_out("waw_v12_clear", 4'b0000, 4'b0011);
    tick();
    cand(1, 0, 0, 0, 0, 11, 0, 1, 0);
    expect_out("waw_v11_edge", 4'b0010, 4'b0011);
    tick();
    cand(1, 0, 0, 0, 0, 6, 0, 1, 1);
    expect_out("waw_v6_7_clear", 4'b0000, 4'b0011);
    tick();
    cand(1, 0, 0, 0, 0, 4, 0, 1, 3);
    expect_out("waw_v4_11", 4'b0011, 4'b0011);
    tick();

    // Group 2 <- v30..v31; grouped sources must not wrap past v31
    cand(1, 0, 0, 0, 0, 30, 0, 1, 1);
    ctl(4'b0100, 4'b0000);
    expect_out("issue_g2", 4'b0000, 4'b0011);
    tick();
    ctl(4'b0000, 4'b0000);
    cand(1, 0, 1, 0, 0, 0, 0, 0, 3);
    expect_out("raw_v0_7_nowrap", 4'b0001, 4'b0111);
    tick();
    cand(1, 24, 1, 0, 0, 0, 0, 0, 3);
    expect_out("raw_v24_31", 4'b0100, 4'b0111);
    tick();
    cand(1, 31, 1, 0, 0, 0, 0, 0, 1);
    expect_out("raw_v31_edge", 4'b0100, 4'b0111);
    tick();

    // Done and start together on group 0: start wins with v20
    cand(1, 0, 0, 0, 0, 20, 0, 1, 0);
    ctl(4'b0001, 4'b0001);
    expect_out("start_done_same", 4'b0000, 4'b0111);
    tick();
    ctl(4'b0000, 4'b0000);
    cand(1, 4, 1, 0, 0, 0, 0, 0, 0);
    expect_out("old_v4_gone", 4'b0000, 4'b0111);
    tick();
    cand(1, 0, 0, 20, 1, 0, 0, 0, 0);
    expect_out("new_v20_raw", 4'b0001, 4'b0111);
    tick();

    // Done alone retires group 1
    cand(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ctl(4'b0000, 4'b0010);
    expect_out("done_g1", 4'b0000, 4'b0111);
    tick();
    ctl(4'b0000, 4'b0000);
    cand(1, 0, 0, 0, 0, 10, 0, 1, 0);
    expect_out("after_done_g1", 4'b0000, 4'b0101);
    tick();

    // Group 3 busy, then a store on group 3 clears it; vd_src hits group 0
    cand(1, 0, 0, 0, 0, 16, 0, 1, 0);
    ctl(4'b1000, 4'b0000);
    expect_out("issue_g3", 4'b0000, 4'b0101);
    tick();
    cand(1, 0, 0, 0, 0, 20, 1, 0, 0);
    ctl(4'b1000, 4'b0000);
    expect_out("store_vd_src", 4'b0001, 4'b1101);
    tick();
    ctl(4'b0000, 4'b0000);
    cand(0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out("store_not_busy", 4'b0000, 4'b0101);
    tick();

    // Multi-bit start captures on groups 1 and 3
    cand(1, 0, 0, 0, 0, 12, 0, 1, 0);
    ctl(4'b1010, 4'b0000);
    expect_out("multi_start", 4'b0000, 4'b0101);
    tick();
    ctl(4'b0000, 4'b0000);
    cand(1, 12, 1, 0, 0, 0, 0, 0, 0);
    expect_out("multi_raw", 4'b1010, 4'b1111);
    tick();

    // Reset with every group busy, then a late done has no effect
    cand(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    cand(1, 20, 1, 30, 1, 12, 1, 1, 3);
    ctl(4'b0000, 4'b1111);
    expect_out("post_reset", 4'b0000, 4'b0000);
    tick();
    ctl(4'b0000, 4'b0000);
    expect_out("late_done_noop", 4'b0000, 4'b0000);
    tick();
    tick();

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
